// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: drives the combinational instruction memory from
// a fetch PC and buffers {pc, inst} pairs in a small prefetch queue for decode.

module imem_fetch_entry (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        i_we,
  input  logic [63:0] i_d,
  output logic [63:0] o_q
);
  logic [63:0] r_q;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn)      r_q <= '0;
    else if (i_we)  r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module imem_fetch_ctrl #(
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int          CW       = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic          Run,
  input  logic          Redirect,
  input  logic [31:0]   RedirectPC,
  output logic [31:0]   ImemAddr,
  input  logic [31:0]   ImemInst,
  output logic          InstValid,
  output logic [31:0]   InstOut,
  output logic [31:0]   InstPC,
  input  logic          InstReady,
  output logic [CW-1:0] Occupancy
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [31:0]   r_fpc;
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_wp;
  logic [CW-1:0] r_cnt;

  logic          w_pop;
  logic          w_push;
  logic          w_full;
  entry_t        w_wdata;
  entry_t        w_head;
  logic [DEPTH-1:0] w_we;
  logic [63:0]   w_q [DEPTH];

  assign w_full  = (r_cnt == CW'(DEPTH));
  // Redirect squashes both handshakes so a flushed head is never consumed.
  assign w_pop   = (r_cnt != '0) & InstReady & ~Redirect;
  assign w_push  = Run & ~Redirect & (~w_full | w_pop);
  assign w_wdata = '{pc: r_fpc, inst: ImemInst};

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign w_we[g] = w_push & (r_wp == AW'(g));
    imem_fetch_entry u_ent (
      .Clk  (Clk),
      .Clrn (Clrn),
      .i_we (w_we[g]),
      .i_d  (w_wdata),
      .o_q  (w_q[g])
    );
  end

  assign w_head = entry_t'(w_q[r_rp]);

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_fpc <= RESET_PC;
      r_rp  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
    end else if (Redirect) begin
      r_fpc <= {RedirectPC[31:2], 2'b00};
      r_rp  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fpc <= r_fpc + 32'd4;
        r_wp  <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // All outputs come straight from registers; no input reaches them combinationally.
  assign ImemAddr  = r_fpc;
  assign InstValid = (r_cnt != '0);
  assign InstOut   = w_head.inst;
  assign InstPC    = w_head.pc;
  assign Occupancy = r_cnt;
endmodule
